// File: rtl/srp_sync_pkg.sv
// Shared types and sizing for the Shapiro-Rudin/Park time synchronizer P-metric path.
package srp_sync_pkg;

   localparam int SRP_DEPTH  = 2096;
   localparam int SRP_ADDR_W = 12;
   localparam int SRP_DATA_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_SCAN  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } srp_state_e;

endpackage

// File: rtl/srp_peak_tracker.sv
// Running signed maximum over a stream of tagged words; the first word after clr loads unconditionally.
module srp_peak_tracker
   import srp_sync_pkg::*;
#(
   parameter int ADDR_W = SRP_ADDR_W,
   parameter int DATA_W = SRP_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     vld,
   input  logic [ADDR_W-1:0]        idx,
   input  logic signed [DATA_W-1:0] data,
   output logic signed [DATA_W-1:0] max_val,
   output logic [ADDR_W-1:0]        max_idx
);

   logic                     first_q;
   logic signed [DATA_W-1:0] max_val_q;
   logic [ADDR_W-1:0]        max_idx_q;

   // Strict greater-than: on equal values the earlier (lower) index is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q   <= 1'b1;
         max_val_q <= '0;
         max_idx_q <= '0;
      end else if (clr) begin
         first_q <= 1'b1;
      end else if (vld && (first_q || (data > max_val_q))) begin
         first_q   <= 1'b0;
         max_val_q <= data;
         max_idx_q <= idx;
      end
   end

   assign max_val = max_val_q;
   assign max_idx = max_idx_q;

endmodule

// File: rtl/srp_bram_scan_ctrl.sv
// Owns the single-port P-metric BRAM: captures one frame, scans it back and reports the peak
// sample, its address, and whether it exceeds the threshold latched at start.
//
//   state | meaning
//   IDLE  | waiting for start; BRAM idle, no samples accepted
//   FILL  | accepting samples, one BRAM write per handshake
//   SCAN  | one BRAM read per cycle, addresses 0..DEPTH-1
//   FLUSH | last read word returns and is folded into the tracker
//   DONE  | peak_valid pulse, result fields captured
module srp_bram_scan_ctrl
   import srp_sync_pkg::*;
#(
   parameter int DEPTH  = SRP_DEPTH,
   parameter int ADDR_W = SRP_ADDR_W,
   parameter int DATA_W = SRP_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [DATA_W-1:0] s_data,
   input  logic signed [DATA_W-1:0] threshold,
   output logic                     bram_en,
   output logic                     bram_we,
   output logic [ADDR_W-1:0]        bram_addr,
   output logic [DATA_W-1:0]        bram_di,
   input  logic [DATA_W-1:0]        bram_dout,
   output logic                     busy,
   output logic                     peak_valid,
   output logic signed [DATA_W-1:0] peak_value,
   output logic [ADDR_W-1:0]        peak_index,
   output logic                     detected
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   srp_state_e               state_q;
   logic [ADDR_W-1:0]        wr_ptr_q;
   logic [ADDR_W-1:0]        rd_ptr_q;
   logic [ADDR_W-1:0]        rd_idx_q;
   logic                     rd_vld_q;
   logic signed [DATA_W-1:0] thr_q;
   logic signed [DATA_W-1:0] peak_value_q;
   logic [ADDR_W-1:0]        peak_index_q;
   logic                     detected_q;

   logic                     fill_hs;
   logic                     in_done;
   logic signed [DATA_W-1:0] trk_max;
   logic [ADDR_W-1:0]        trk_idx;
   logic                     trk_det;

   assign fill_hs = (state_q == ST_FILL) && s_valid;
   assign in_done = (state_q == ST_DONE);
   assign trk_det = trk_max > thr_q;

   srp_peak_tracker #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_tracker (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state_q == ST_IDLE),
      .vld     (rd_vld_q),
      .idx     (rd_idx_q),
      .data    (bram_dout),
      .max_val (trk_max),
      .max_idx (trk_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rd_idx_q     <= '0;
         rd_vld_q     <= 1'b0;
         thr_q        <= '0;
         peak_value_q <= '0;
         peak_index_q <= '0;
         detected_q   <= 1'b0;
      end else begin
         rd_vld_q <= 1'b0;
         // DONE already showed the result on the outputs, so it is kept even if abort lands here.
         if (in_done) begin
            peak_value_q <= trk_max;
            peak_index_q <= trk_idx;
            detected_q   <= trk_det;
         end
         if (abort) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     state_q  <= ST_FILL;
                     wr_ptr_q <= '0;
                     thr_q    <= threshold;
                  end
               end
               ST_FILL: begin
                  if (s_valid) begin
                     if (wr_ptr_q == LAST) begin
                        state_q  <= ST_SCAN;
                        rd_ptr_q <= '0;
                     end else begin
                        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                     end
                  end
               end
               ST_SCAN: begin
                  rd_vld_q <= 1'b1;
                  rd_idx_q <= rd_ptr_q;
                  if (rd_ptr_q == LAST) state_q <= ST_FLUSH;
                  else                  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
               end
               ST_FLUSH: state_q <= ST_DONE;
               ST_DONE:  state_q <= ST_IDLE;
               default:  state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign s_ready    = (state_q == ST_FILL);
   assign bram_en    = fill_hs || (state_q == ST_SCAN);
   assign bram_we    = fill_hs;
   assign bram_addr  = (state_q == ST_SCAN) ? rd_ptr_q :
                       (state_q == ST_FILL) ? wr_ptr_q : '0;
   assign bram_di    = fill_hs ? s_data : '0;
   assign busy       = (state_q != ST_IDLE);
   assign peak_valid = in_done;
   assign peak_value = in_done ? trk_max : peak_value_q;
   assign peak_index = in_done ? trk_idx : peak_index_q;
   assign detected   = in_done ? trk_det : detected_q;

endmodule

// File: tb/tb_srp_bram_scan_ctrl.sv
// Directed bench: a 16-word instance exercised frame by frame, plus one full-depth frame.
module tb_srp_bram_scan_ctrl;
   import srp_sync_pkg::*;

   localparam int D  = 16;
   localparam int AW = SRP_ADDR_W;
   localparam int DW = SRP_DATA_W;
   localparam int D2 = SRP_DEPTH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                 start = 1'b0, abort = 1'b0, s_valid = 1'b0;
   logic signed [DW-1:0] s_data = '0, threshold = '0;
   logic                 s_ready, bram_en, bram_we, busy, peak_valid, detected;
   logic [AW-1:0]        bram_addr, peak_index;
   logic [DW-1:0]        bram_di;
   logic [DW-1:0]        bram_dout = '0;
   logic signed [DW-1:0] peak_value;

   srp_bram_scan_ctrl #(.DEPTH(D), .ADDR_W(AW), .DATA_W(DW)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .threshold(threshold),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_di(bram_di),
      .bram_dout(bram_dout), .busy(busy), .peak_valid(peak_valid),
      .peak_value(peak_value), .peak_index(peak_index), .detected(detected)
   );

   logic                 b_start = 1'b0, b_valid = 1'b0;
   logic signed [DW-1:0] b_data = '0, b_thr = '0;
   logic                 b_ready, b_en, b_we, b_busy, b_pv, b_det;
   logic [AW-1:0]        b_addr, b_pidx;
   logic [DW-1:0]        b_di;
   logic [DW-1:0]        b_dout = '0;
   logic signed [DW-1:0] b_pval;

   srp_bram_scan_ctrl u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(b_start), .abort(1'b0),
      .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data), .threshold(b_thr),
      .bram_en(b_en), .bram_we(b_we), .bram_addr(b_addr), .bram_di(b_di),
      .bram_dout(b_dout), .busy(b_busy), .peak_valid(b_pv),
      .peak_value(b_pval), .peak_index(b_pidx), .detected(b_det)
   );

   logic [DW-1:0] mem1 [4096];
   logic [DW-1:0] mem2 [4096];

   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) mem1[bram_addr] <= bram_di;
         else         bram_dout <= mem1[bram_addr];
      end
      if (b_en) begin
         if (b_we) mem2[b_addr] <= b_di;
         else      b_dout <= mem2[b_addr];
      end
   end

   int cyc = 0, wr_cnt = 0, we_bad = 0, pv_cnt = 0;
   logic [AW-1:0] wlog_a [256];
   logic [DW-1:0] wlog_d [256];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bram_en && bram_we) begin
         if (wr_cnt < 256) begin
            wlog_a[wr_cnt] <= bram_addr;
            wlog_d[wr_cnt] <= bram_di;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if ((bram_we && !s_ready) || (b_we && !b_ready)) we_bad <= we_bad + 1;
      if (peak_valid) pv_cnt <= pv_cnt + 1;
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
      end
   endtask

   logic signed [DW-1:0] frame [D];
   int hs_cyc = 0, pv_lat = 0;
   bit got;

   task automatic fill(input logic signed [DW-1:0] thr, input bit rnd, input int n);
      int i = 0, guard = 0;
      @(negedge clk);
      threshold = thr;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      threshold = '0;
      while (i < n && guard < 400) begin
         s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_data  = frame[i];
         if (s_valid && s_ready) begin
            hs_cyc = cyc;
            i++;
         end
         guard++;
         @(negedge clk);
      end
      if (i < n) chk("fill_timeout", i, n);
      s_data = '0;
   endtask

   task automatic wait_peak(input int lim);
      got = 1'b0;
      for (int k = 0; k < lim && !got; k++) begin
         @(negedge clk);
         if (peak_valid) begin
            got = 1'b1;
            pv_lat = cyc - hs_cyc;
         end
      end
   endtask

   task automatic run_check(input string tag, input logic signed [DW-1:0] ev, input int ei,
                            input bit ed);
      int pv0;
      pv0 = pv_cnt;
      s_valid = 1'b0;
      wait_peak(3 * D);
      chk({tag, "_pv_seen"}, got, 1);
      if (got) begin
         chk({tag, "_latency"}, pv_lat, D + 2);
         chk({tag, "_value"}, peak_value, ev);
         chk({tag, "_index"}, peak_index, ei);
         chk({tag, "_detected"}, detected, ed);
      end
      @(negedge clk);
      chk({tag, "_pv_one_cycle"}, peak_valid, 0);
      chk({tag, "_idle_after"}, busy, 0);
      chk({tag, "_value_held"}, peak_value, ev);
      chk({tag, "_pv_count"}, pv_cnt - pv0, 1);
   endtask

   function automatic logic signed [DW-1:0] f2(input int i);
      if (i == 1500 || i == 2095) return 32'sd9000;
      return 32'((i * 13) % 997 - 400);
   endfunction

   initial begin
      int wbase, pv0, i;

      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_bram_en", bram_en, 0);
      chk("rst_bram_we", bram_we, 0);
      chk("rst_bram_addr", bram_addr, 0);
      chk("rst_peak_valid", peak_valid, 0);
      chk("rst_peak_value", peak_value, 0);
      chk("rst_peak_index", peak_index, 0);
      chk("rst_detected", detected, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: ramp, s_valid held high across FILL->SCAN
      for (int k = 0; k < D; k++) frame[k] = k;
      fill(32'sd10, 1'b0, D);
      chk("t1_scan_no_ready", s_ready, 0);
      chk("t1_scan_no_we", bram_we, 0);
      run_check("t1", 32'sd15, 15, 1'b1);

      // 2: negative frame, signed compare
      for (int k = 0; k < D; k++) frame[k] = -32'sd5;
      frame[7] = -32'sd1;
      fill(32'sd0, 1'b0, D);
      run_check("t2", -32'sd1, 7, 1'b0);

      // 3: equal peaks, threshold equal to peak is not a detect
      for (int k = 0; k < D; k++) frame[k] = k;
      frame[3] = 32'sd100;
      frame[12] = 32'sd100;
      fill(32'sd100, 1'b0, D);
      run_check("t3", 32'sd100, 3, 1'b0);

      // 4: random s_valid, write order, start while busy
      chk("t4_idle_no_ready", s_ready, 0);
      for (int k = 0; k < D; k++) frame[k] = 50 - 3 * k;
      wbase = wr_cnt;
      fill(-32'sd1, 1'b1, D);
      chk("t4_scan_no_ready", s_ready, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_check("t4", 32'sd50, 0, 1'b1);
      chk("t4_write_count", wr_cnt - wbase, D);
      for (int k = 0; k < D; k++) begin
         chk($sformatf("t4_wr_addr%0d", k), wlog_a[wbase + k], k);
         chk($sformatf("t4_wr_data%0d", k), wlog_d[wbase + k], 50 - 3 * k);
      end

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle", busy, 0);

      // 5: abort in SCAN cycle 5
      for (int k = 0; k < D; k++) frame[k] = 32'sd1000;
      fill(32'sd0, 1'b0, D);
      s_valid = 1'b0;
      repeat (4) @(negedge clk);
      pv0 = pv_cnt;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_abort_idle", busy, 0);
      chk("t5_abort_en", bram_en, 0);
      chk("t5_abort_ready", s_ready, 0);
      repeat (25) @(negedge clk);
      chk("t5_no_pv", pv_cnt - pv0, 0);
      chk("t5_held_value", peak_value, 50);
      chk("t5_held_index", peak_index, 0);
      chk("t5_held_det", detected, 1);
      for (int k = 0; k < D; k++) frame[k] = k;
      frame[9] = 32'sd77;
      fill(32'sd76, 1'b0, D);
      run_check("t5_restart", 32'sd77, 9, 1'b1);

      // 6: reset mid-FILL
      for (int k = 0; k < D; k++) frame[k] = 20 - (k - 6) * (k - 6);
      fill(32'sd25, 1'b0, 5);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_ready", s_ready, 0);
      chk("t6_rst_en", bram_en, 0);
      chk("t6_rst_value", peak_value, 0);
      chk("t6_rst_index", peak_index, 0);
      chk("t6_rst_det", detected, 0);
      s_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill(32'sd25, 1'b0, D);
      run_check("t6", 32'sd20, 6, 1'b0);

      // full-depth frame on the default-parameter instance
      @(negedge clk);
      b_thr = 32'sd8999;
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      b_thr = '0;
      i = 0;
      while (i < D2) begin
         b_valid = 1'b1;
         b_data = f2(i);
         if (b_ready) begin
            hs_cyc = cyc;
            i++;
         end else begin
            break;
         end
         @(negedge clk);
      end
      chk("full_fill_count", i, D2);
      b_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < D2 + 100 && !got; k++) begin
         @(negedge clk);
         if (b_pv) begin
            got = 1'b1;
            pv_lat = cyc - hs_cyc;
         end
      end
      chk("full_pv_seen", got, 1);
      if (got) begin
         chk("full_latency", pv_lat, D2 + 2);
         chk("full_value", b_pval, 9000);
         chk("full_index", b_pidx, 1500);
         chk("full_detected", b_det, 1);
      end

      chk("we_outside_fill", we_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
